// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller sitting between the PC register,
// the instruction memory and the IF/ID register.
//  - Issues one instruction-memory request at a time at address pc_i and
//    holds it stable until imem_ready_i.
//  - Steps the PC by 4 on each completed fetch, or redirects it on branch_i.
//  - A one-entry skid buffer absorbs a returning word while IF/ID is stalled.
//  - A branch that arrives mid-request parks in SQUASH until the stale word
//    returns, then redirects the PC to the latched target.
// Optional feature: define FETCH_TIMEOUT_EN to add an 8-bit fetch-timeout
// counter that raises a sticky err_o. Without it, err_o is tied to 0.
module fetch_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    output logic        pc_write_o,
    output logic [31:0] pc_next_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        flush_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_d;
    logic [31:0] skid_q;
    logic        skid_valid_q;
    logic [31:0] target_q;

    // Outstanding request completes this cycle.
    logic done;
    // IF/ID takes inst_o at the coming edge.
    logic consume;
    // Returned word is kept (sequential fetch, no redirect).
    logic accept;
    // Fetch-timeout fires at the coming edge.
    logic timeout;

    assign done        = imem_req_o & imem_ready_i;
    assign consume     = inst_valid_o & ~stall_i;
    assign imem_addr_o = pc_i;
    assign flush_o     = branch_i;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       err_q;

    // The 255th waiting cycle is the one where the counter sits at 254.
    assign timeout = imem_req_o & ~imem_ready_i & (tmo_cnt_q == 8'd254);
    assign err_o   = err_q;

    // Count cycles spent waiting on memory; a completed request restarts it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_cnt_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            if (done) begin
                tmo_cnt_q <= 8'd0;
            end else if (imem_req_o) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    // Control state, request flag and latched branch target.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            imem_req_o <= 1'b0;
            target_q   <= 32'h0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            imem_req_o <= req_d;
            if (branch_i) begin
                target_q <= branch_target_i;
            end
        end
    end

    // Next state, request issue and PC update.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        req_d      = imem_req_o;
        pc_write_o = 1'b0;
        pc_next_o  = pc_i + 32'd4;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if (branch_i) begin
                    pc_write_o = 1'b1;
                    pc_next_o  = branch_target_i;
                end
                if (start_i && !err_o) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (done) begin
                    req_d      = 1'b0;
                    pc_write_o = 1'b1;
                    if (branch_i) begin
                        pc_next_o = branch_target_i;
                    end else begin
                        accept = 1'b1;
                    end
                    if (!start_i) begin
                        state_d = IDLE;
                    end
                end else if (imem_req_o) begin
                    // Stale word still in flight: wait for it in SQUASH.
                    if (branch_i) begin
                        state_d = SQUASH;
                    end
                end else begin
                    if (branch_i) begin
                        pc_write_o = 1'b1;
                        pc_next_o  = branch_target_i;
                    end
                    if (!start_i) begin
                        state_d = IDLE;
                    end else if (!skid_valid_q) begin
                        req_d = 1'b1;
                    end
                end
            end

            SQUASH: begin
                if (done) begin
                    req_d      = 1'b0;
                    pc_write_o = 1'b1;
                    pc_next_o  = branch_i ? branch_target_i : target_q;
                    state_d    = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (timeout) begin
            req_d   = 1'b0;
            state_d = IDLE;
        end
    end

    // IF/ID register and skid buffer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            inst_o       <= 32'h0;
            inst_valid_o <= 1'b0;
            skid_q       <= 32'h0;
            skid_valid_q <= 1'b0;
        end else if (branch_i) begin
            inst_valid_o <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                inst_o       <= skid_q;
                skid_valid_q <= accept;
                if (accept) begin
                    skid_q <= imem_rdata_i;
                end
            end else if (accept) begin
                inst_o <= imem_rdata_i;
            end else begin
                inst_valid_o <= 1'b0;
            end
        end else if (accept) begin
            if (!inst_valid_o) begin
                inst_o       <= imem_rdata_i;
                inst_valid_o <= 1'b1;
            end else begin
                skid_q       <= imem_rdata_i;
                skid_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL: clk_i  in  1  clock; all state updates on rising edge.
REQ-002 SHALL: rst_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: start_i  in  1  fetch enable; 0 = issue no new requests.
REQ-004 SHALL: pc_i  in  32  current PC from the PC register.
REQ-005 SHALL: pc_write_o  out  1  combinational PC write enable; PC loads pc_next_o on that edge.
REQ-006 SHALL: pc_next_o  out  32  combinational next PC.
REQ-007 SHALL: imem_req_o  out  1  instruction-memory request (registered).
REQ-008 SHALL: imem_addr_o  out  32  request address, equal to pc_i.
REQ-009 SHALL: imem_ready_i  in  1  read data valid; completes the request in that cycle.
REQ-010 SHALL: imem_rdata_i  in  32  instruction word.
REQ-011 SHALL: inst_o / inst_valid_o  out  32/1  registered instruction to IF/ID, with valid.
REQ-012 SHALL: stall_i  in  1  downstream hold; inst_o is consumed on an edge where inst_valid_o=1 and stall_i=0.
REQ-013 SHALL: branch_i / branch_target_i  in  1/32  taken-branch redirect pulse and target.
REQ-014 SHALL: flush_o  out  1  combinational IF/ID flush, equal to branch_i.
REQ-015 SHALL: err_o  out  1  sticky fetch-timeout error.

Function
REQ-016 SHALL: FSM states IDLE, FETCH, SQUASH; IDLE->FETCH on the edge after start_i=1.
REQ-017 SHALL: once imem_req_o rises it stays high with imem_addr_o stable until the imem_ready_i cycle; pc_write_o stays 0 while a request is outstanding, except in the ready cycle.
REQ-018 SHALL: in FETCH, raise imem_req_o only when start_i=1, the one-entry skid buffer is empty, and no request is outstanding.
REQ-019 SHALL: ready in FETCH with branch_i=0 -> pc_write_o=1, pc_next_o=pc_i+4 (32-bit wrap, 0xFFFFFFFC->0x0); data goes to inst_o if the slot is free or being consumed, else to skid.
REQ-020 SHALL: when inst_o is consumed and skid is full, move skid into inst_o on the same edge; otherwise clear inst_valid_o.
REQ-021 SHALL: inst_o and inst_valid_o stay stable while stall_i=1.
REQ-022 SHALL: branch_i with no request outstanding, or coinciding with ready -> pc_write_o=1, pc_next_o=branch_target_i, any returned data discarded.
REQ-023 SHALL: branch_i with a request outstanding and ready=0 -> latch target, enter SQUASH; at ready, discard data, pc_write_o=1, pc_next_o=latched target, return to FETCH.
REQ-024 SHALL: branch_i clears inst_valid_o and skid on the next edge; branch has priority over sequential update.
REQ-025 SHALL: a second branch_i in SQUASH overwrites the latched target.
REQ-026 SHALL: start_i falling mid-request -> the request completes and its data is kept; go to IDLE after ready, with skid/inst_o retained.

Reset
REQ-027 SHALL: rst_i=0 immediately forces IDLE, imem_req_o=0, inst_o=32'h0, inst_valid_o=0, skid empty, latched target 0, err_o=0, and any timeout counter 0, including mid-request; pc_write_o and flush_o follow their inputs.
REQ-028 SHALL: after reset release, the first request address is the current pc_i.

Configuration
REQ-029 SHALL: with FETCH_TIMEOUT_EN defined, an 8-bit counter counts cycles with imem_req_o=1 and imem_ready_i=0; at 255, set err_o=1 (sticky until reset), drop imem_req_o, enter IDLE, and ignore start_i thereafter.
REQ-030 SHALL: without FETCH_TIMEOUT_EN, there is no counter, err_o is tied 0, and waits are unbounded.

Verification
REQ-031 SHALL: pc_i=0x100, start_i=1, ready 1 cycle after each request, stall_i=0 -> inst_o sequence from 0x100,0x104,0x108, with pc_write_o pulses.
REQ-032 SHALL: stall_i=1 for 3 cycles with a second word returned -> inst_o held, skid filled, no new request; on release, both words are delivered in order and none is lost.
REQ-033 SHALL: branch_i to 0x200 while ready is low for 4 cycles -> flush_o=1, SQUASH entered, old data dropped, pc_next_o=0x200 at ready, next fetch at 0x200.
REQ-034 SHALL: pc_i=0xFFFFFFFC with ready -> pc_next_o=0x00000000.
REQ-035 SHALL: rst_i low mid-request -> imem_req_o=0 and inst_valid_o=0 without a clock edge.
REQ-036 SHALL: FETCH_TIMEOUT_EN with ready held 0 -> err_o=1 after 255 cycles and imem_req_o=0.
